// File: rtl/shift_unit_pkg.sv
// Shared encodings for the iterative shifter: ALU decoder select codes and FSM states.
package shift_unit_pkg;

    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_PASS = 2'b00;
    localparam logic [SEL_W-1:0] SEL_SLL  = 2'b01;
    localparam logic [SEL_W-1:0] SEL_SRL  = 2'b10;
    localparam logic [SEL_W-1:0] SEL_SRA  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_unit.sv
// Iterative one-bit-per-clock shifter with start/busy/done handshake for
// the execute stage; pass and zero-amount requests complete in one cycle.
module shift_unit
    import shift_unit_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SEL_W-1:0]   shift_sel,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SEL_W-1:0]   op_q, op_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    function automatic logic [WIDTH-1:0] shift_one(input logic [SEL_W-1:0] op,
                                                   input logic [WIDTH-1:0] d);
        case (op)
            SEL_SLL: return {d[WIDTH-2:0], 1'b0};
            SEL_SRL: return {1'b0, d[WIDTH-1:1]};
            SEL_SRA: return {d[WIDTH-1], d[WIDTH-1:1]};
            default: return d;
        endcase
    endfunction

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    data_d = operand;
                    op_d   = shift_sel;
                    cnt_d  = shamt;
                    if (shift_sel == SEL_PASS || shamt == SHAMT_W'(0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_d = shift_one(op_q, data_q);
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            op_q    <= SEL_PASS;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = data_q;

endmodule
